// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle control unit and datapath. Serves
// fetch, load and store requests against a unified, word-addressed
// instruction/data RAM. Every access takes a fixed, parameterised number of
// wait states. Completion is signalled by a single-cycle ready pulse, so the
// control FSM can stall until the access has landed.
//
// Parameters
//   ADDR_W       byte-address width
//   DATA_W       data word width
//   DEPTH_WORDS  RAM depth in words (valid byte addresses 0 .. 4*DEPTH_WORDS-1)
//   WAIT_CYCLES  wait states between request capture and response (0 allowed)
//
// Ports
//   CLK    in   clock, rising-edge active
//   RSTN   in   asynchronous active-low reset
//   req    in   access request, held by the initiator until ready
//   we     in   1 = store, 0 = fetch/load
//   addr   in   byte address, must be word-aligned
//   wdata  in   store data
//   busy   out  high while an access is in flight (WAIT and RESP states)
//   ready  out  one-cycle completion pulse
//   err    out  qualifies ready: access rejected (misaligned or out of range)
//   rdata  out  read data, valid with ready for a good read and held until
//               the next good read completes
//
// Timing
//   If req is sampled at edge N, the access is performed at the edge that
//   enters RESP (edge N+WAIT_CYCLES). ready is registered from RESP, so it is
//   high in the cycle after edge N+WAIT_CYCLES+1. That cycle is already IDLE,
//   so a req still high there is taken as a new access.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ready,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  // Request as captured in IDLE; WAIT works only from these copies.
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  // The access performed on the edge entering RESP.
  logic              acc_fire;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_bad;
  logic [IDX_W-1:0]  acc_idx;

  // Error status of the access currently in RESP, emitted alongside ready.
  logic              resp_err;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Rejects misaligned addresses and word indices beyond the RAM.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_W'(DEPTH_WORDS));
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and access selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_fire   = 1'b0;
    acc_we     = cap_we;
    acc_addr   = cap_addr;
    acc_wdata  = cap_wdata;

    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = CNT_LOAD;
          end else begin
            // With no wait states the access lands on the capture edge, so
            // the live request is used rather than the not-yet-captured copy.
            state_next = S_RESP;
            acc_fire   = 1'b1;
            acc_we     = we;
            acc_addr   = addr;
            acc_wdata  = wdata;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_next = S_RESP;
          acc_fire   = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    acc_bad = addr_bad(acc_addr);
    acc_idx = acc_addr[IDX_W+1:2];
  end

  // ---------------------------------------------------------------------------
  // State, capture and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      resp_err  <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;

      if (state == S_IDLE && req) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end

      busy  <= (state_next != S_IDLE);
      ready <= (state == S_RESP);
      err   <= (state == S_RESP) && resp_err;

      if (acc_fire) begin
        resp_err <= acc_bad;
        if (!acc_we && !acc_bad) begin
          rdata <= mem[acc_idx];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port (contents deliberately survive reset)
  // ---------------------------------------------------------------------------
  // RSTN gates the write so a zero-wait store presented during reset is
  // discarded rather than landing in the RAM.
  always_ff @(posedge CLK) begin
    if (RSTN && acc_fire && acc_we && !acc_bad) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

`ifndef SYNTHESIS
  err_only_with_ready: assert property (
    @(posedge CLK) disable iff (!RSTN) err |-> ready);
  ready_is_single_pulse: assert property (
    @(posedge CLK) disable iff (!RSTN) ready |=> !ready);
`endif

endmodule
